// File: rtl/jtbubl_dwnld_if.sv
// Download bus between the host/game side and the ROM download front end.
// Groups the ioctl byte stream, the SDRAM programming handshake and the
// video PROM write port.
//   master : drives downloading/ioctl_*/sdram_ack, receives prog_*/prom_*
//   slave  : the download front end (jtbubl_dwnld)
interface jtbubl_dwnld_if;
  logic        downloading;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wr;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        sdram_ack;
  logic        prom_we;
  logic [7:0]  prom_addr;
  logic [3:0]  prom_data;

  modport master (
    output downloading, ioctl_addr, ioctl_dout, ioctl_wr, sdram_ack,
    input  prog_addr, prog_data, prog_mask, prog_we,
    input  prom_we, prom_addr, prom_data
  );

  modport slave (
    input  downloading, ioctl_addr, ioctl_dout, ioctl_wr, sdram_ack,
    output prog_addr, prog_data, prog_mask, prog_we,
    output prom_we, prom_addr, prom_data
  );
endinterface

// File: rtl/jtbubl_dwnld.sv
// ROM download front end for the Bubble Bobble / Tokio core.
// Bytes below PROM_START are queued in a small FIFO and written to SDRAM one
// at a time over a prog_we/sdram_ack handshake. Bytes at or above PROM_START
// go straight to the video PROM port as a one-cycle strobe. Also latches the
// Tokio set flag from byte 0 and signals when a download has fully drained.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   bus (slave)     ioctl input stream, SDRAM programming port, PROM port
//   tokio_o         1 when byte 0 of the last load was 8'h7e
//   dwnld_busy_o    downloading, or bytes still queued / in flight
//   dwnld_done_o    one-cycle pulse once a finished download has drained
//   ovf_o           sticky: a byte was dropped because the FIFO was full
module jtbubl_dwnld #(
  parameter logic [24:0] PROM_START = 25'hC_0000,
  parameter int          FIFO_AW    = 1
) (
  input  logic          clk,
  input  logic          rst,
  jtbubl_dwnld_if.slave bus,
  output logic          tokio_o,
  output logic          dwnld_busy_o,
  output logic          dwnld_done_o,
  output logic          ovf_o
);
  localparam int         DEPTH   = 1 << FIFO_AW;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  // Only the low byte of the PROM offset is used, and the low bits of a
  // difference depend only on the low bits of the operands.
  localparam logic [7:0] PROM_LO = PROM_START[7:0];

  typedef struct packed {
    logic [21:0] waddr;
    logic        odd;
    logic [7:0]  data;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           head;
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]       state_q, state_d;
  logic [21:0]      prog_addr_q, prog_addr_d;
  logic [7:0]       prog_data_q, prog_data_d;
  logic [1:0]       prog_mask_q, prog_mask_d;
  logic             prog_we_q, prog_we_d;
  logic             prom_we_q, prom_we_d;
  logic [7:0]       prom_addr_q, prom_addr_d;
  logic [3:0]       prom_data_q, prom_data_d;
  logic             tokio_q, tokio_d;
  logic             ovf_q, ovf_d;
  logic             armed_q, armed_d;

  logic       empty, full, in_prom, push, pop, push_ok, done;
  logic [7:0] prom_off;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  // Pointers carry one extra wrap bit: same slot but different lap means full.
  assign full     = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                    (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign in_prom  = (bus.ioctl_addr >= PROM_START);
  assign push     = bus.ioctl_wr && !in_prom;
  assign pop      = (state_q == ST_IDLE) && !empty;
  // A same-cycle pop frees the slot being written, so a full FIFO still accepts.
  assign push_ok  = push && (!full || pop);
  assign head     = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign prom_off = bus.ioctl_addr[7:0] - PROM_LO;
  assign done     = armed_q && !bus.downloading && empty && (state_q == ST_IDLE);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    state_d     = state_q;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    prog_mask_d = prog_mask_q;
    prog_we_d   = prog_we_q;
    prom_we_d   = 1'b0;
    prom_addr_d = prom_addr_q;
    prom_data_d = prom_data_q;
    tokio_d     = tokio_q;
    ovf_d       = ovf_q;
    armed_d     = armed_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (push && !push_ok) ovf_d = 1'b1;

    if (bus.ioctl_wr && in_prom) begin
      prom_we_d   = 1'b1;
      prom_addr_d = prom_off;
      prom_data_d = bus.ioctl_dout[3:0];
    end

    if (bus.ioctl_wr && bus.ioctl_addr == 25'd0)
      tokio_d = (bus.ioctl_dout == 8'h7e);

    // Armed while a download is seen; disarmed by the single done pulse.
    if (bus.downloading) armed_d = 1'b1;
    else if (done)       armed_d = 1'b0;

    case (state_q)
      ST_IDLE: if (pop) begin
        rd_ptr_d    = rd_ptr_q + 1'b1;
        prog_addr_d = head.waddr;
        prog_data_d = head.data;
        prog_mask_d = {~head.odd, head.odd};
        prog_we_d   = 1'b1;
        state_d     = ST_REQ;
      end
      ST_REQ: if (bus.sdram_ack) begin
        prog_we_d = 1'b0;
        state_d   = ST_GAP;
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= ST_IDLE;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      prog_mask_q <= '0;
      prog_we_q   <= 1'b0;
      prom_we_q   <= 1'b0;
      prom_addr_q <= '0;
      prom_data_q <= '0;
      tokio_q     <= 1'b0;
      ovf_q       <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      prog_mask_q <= prog_mask_d;
      prog_we_q   <= prog_we_d;
      prom_we_q   <= prom_we_d;
      prom_addr_q <= prom_addr_d;
      prom_data_q <= prom_data_d;
      tokio_q     <= tokio_d;
      ovf_q       <= ovf_d;
      armed_q     <= armed_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok && !rst)
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= '{waddr: bus.ioctl_addr[22:1],
                                       odd:   bus.ioctl_addr[0],
                                       data:  bus.ioctl_dout};
  end

  assign bus.prog_addr = prog_addr_q;
  assign bus.prog_data = prog_data_q;
  assign bus.prog_mask = prog_mask_q;
  assign bus.prog_we   = prog_we_q;
  assign bus.prom_we   = prom_we_q;
  assign bus.prom_addr = prom_addr_q;
  assign bus.prom_data = prom_data_q;

  assign tokio_o      = tokio_q;
  assign ovf_o        = ovf_q;
  assign dwnld_done_o = done;
  assign dwnld_busy_o = bus.downloading || !empty || prog_we_q;
endmodule
